// File: rtl/popcnt_arbiter.sv
// Two-requester round-robin arbiter that accumulates the popcount of each beat of a frame.
// Build option: define POPCNT_SAT_EN for a saturating accumulator (default build wraps).
module popcnt_arbiter #(
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [3:0]       req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [3:0]       req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [ACC_W-1:0] res_count,
  output logic             res_ovf
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

  state_t           r_state;
  state_t           w_next;
  logic             r_grant;
  logic             r_prio;
  logic             r_req0_ready;
  logic             r_req1_ready;
  logic             r_res_valid;
  logic             r_res_id;
  logic             r_ovf;
  logic [ACC_W-1:0] r_acc;
  logic             w_grant_sel;
  logic             w_grant_nxt;
  logic             w_beat;
  logic             w_last;
  logic [3:0]       w_data;
  logic [ACC_W:0]   w_sum;

  function automatic logic [2:0] popcount4(input logic [3:0] d);
    return {2'b00, d[0]} + {2'b00, d[1]} + {2'b00, d[2]} + {2'b00, d[3]};
  endfunction

  // Arbitration, beat qualification and accumulator sum
  always_comb begin
    w_grant_sel = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant_sel = r_prio;
    end else if (req1_valid) begin
      w_grant_sel = 1'b1;
    end else begin
      w_grant_sel = 1'b0;
    end
    w_grant_nxt = (r_state == IDLE) ? w_grant_sel : r_grant;
    w_data      = r_grant ? req1_data : req0_data;
    w_last      = r_grant ? req1_last : req0_last;
    w_beat      = r_grant ? (req1_valid & r_req1_ready) : (req0_valid & r_req0_ready);
    w_sum       = {1'b0, r_acc} + {{(ACC_W-2){1'b0}}, popcount4(w_data)};
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req0_valid || req1_valid) w_next = RUN;
        else                          w_next = IDLE;
      end
      RUN: begin
        if (w_beat && w_last) w_next = RESULT;
        else                  w_next = RUN;
      end
      RESULT: begin
        if (res_ready) w_next = IDLE;
        else           w_next = RESULT;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Grant, ready, accumulator and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_grant      <= 1'b0;
      r_prio       <= 1'b0;
      r_req0_ready <= 1'b0;
      r_req1_ready <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_id     <= 1'b0;
      r_ovf        <= 1'b0;
      r_acc        <= {ACC_W{1'b0}};
    end else begin
      r_grant      <= w_grant_nxt;
      r_req0_ready <= (w_next == RUN) && !w_grant_nxt;
      r_req1_ready <= (w_next == RUN) &&  w_grant_nxt;
      if (w_beat) begin
`ifdef POPCNT_SAT_EN
        r_acc <= w_sum[ACC_W] ? ACC_MAX : w_sum[ACC_W-1:0];
`else
        r_acc <= w_sum[ACC_W-1:0];
`endif
        if (w_sum[ACC_W]) r_ovf <= 1'b1;
        if (w_last) begin
          r_res_valid <= 1'b1;
          r_res_id    <= r_grant;
        end
      end else if ((r_state == RESULT) && res_ready) begin
        // The requester just served loses priority for the next contention
        r_res_valid <= 1'b0;
        r_acc       <= {ACC_W{1'b0}};
        r_ovf       <= 1'b0;
        r_prio      <= ~r_grant;
      end
    end
  end

  assign req0_ready = r_req0_ready;
  assign req1_ready = r_req1_ready;
  assign res_valid  = r_res_valid;
  assign res_id     = r_res_id;
  assign res_count  = r_acc;
  assign res_ovf    = r_ovf;

endmodule

// File: tb/tb_popcnt_arbiter.sv
// Self-checking bench for popcnt_arbiter: directed scenarios followed by random frames,
// checked against a frame-level arithmetic model of arbitration and popcount totals.
module tb_popcnt_arbiter;
  localparam int ACC_W = 8;
  localparam int MAXV  = (1 << ACC_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
  logic [3:0] req0_data = 4'h0, req1_data = 4'h0;
  logic req0_ready, req1_ready, res_valid, res_id, res_ovf;
  logic res_ready = 1'b0;
  logic [ACC_W-1:0] res_count;

  int n_chk = 0;
  int n_fail = 0;
  int m_prio = 0;
  logic [3:0] q_data[$];

  popcnt_arbiter #(.ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_count(res_count), .res_ovf(res_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int expc(input int total);
`ifdef POPCNT_SAT_EN
    return (total > MAXV) ? MAXV : total;
`else
    return total % (MAXV + 1);
`endif
  endfunction

  function automatic logic rdy(input int k);
    return (k == 1) ? req1_ready : req0_ready;
  endfunction

  task automatic set_req(input int k, input logic v, input logic [3:0] d, input logic l);
    if (k == 1) begin
      req1_valid = v; req1_data = d; req1_last = l;
    end else begin
      req0_valid = v; req0_data = d; req0_last = l;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rdy0"}, req0_ready, 0);
    check({tag, "_rdy1"}, req1_ready, 0);
    check({tag, "_valid"}, res_valid, 0);
    check({tag, "_count"}, res_count, 0);
    check({tag, "_ovf"}, res_ovf, 0);
  endtask

  // Drives q_data as one frame and checks arbitration, handshakes and the result.
  task automatic run_frame(input int id, input bit contend, input int stall_at,
                           input int stall_len, input int hold);
    int g, o, total, budget;
    g = contend ? m_prio : id;
    o = 1 - g;
    total = 0;
    if (contend) set_req(o, 1'b1, 4'($urandom), 1'($urandom));
    for (int b = 0; b < q_data.size(); b++) begin
      if (b == stall_at && stall_len > 0) begin
        set_req(g, 1'b0, 4'hF, 1'b1);
        for (int s = 0; s < stall_len; s++) begin
          step();
          check("stall_count", res_count, expc(total));
          check("stall_ovf", res_ovf, (total > MAXV) ? 1 : 0);
          check("stall_resvalid", res_valid, 0);
          check("stall_other_rdy", rdy(o), 0);
        end
      end
      set_req(g, 1'b1, q_data[b], (b == q_data.size() - 1) ? 1'b1 : 1'b0);
      budget = 0;
      while (rdy(g) !== 1'b1 && budget < 20) begin
        check("wait_other_rdy", rdy(o), 0);
        step();
        budget++;
      end
      check("beat_ready", rdy(g), 1);
      check("other_rdy", rdy(o), 0);
      step();
      total += $countones(q_data[b]);
    end
    set_req(g, 1'b0, 4'h0, 1'b0);
    set_req(o, 1'b0, 4'h0, 1'b0);
    for (int h = 0; h <= hold; h++) begin
      check("res_valid", res_valid, 1);
      check("res_id", res_id, g);
      check("res_count", res_count, expc(total));
      check("res_ovf", res_ovf, (total > MAXV) ? 1 : 0);
      check("result_rdy0", req0_ready, 0);
      check("result_rdy1", req1_ready, 0);
      if (h < hold) step();
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check_idle_outputs("after_consume");
    m_prio = 1 - g;
  endtask

  initial begin
    int len;
    step();
    step();
    check("rst_rdy0", req0_ready, 0);
    check("rst_rdy1", req1_ready, 0);
    check("rst_valid", res_valid, 0);
    check("rst_id", res_id, 0);
    check("rst_count", res_count, 0);
    check("rst_ovf", res_ovf, 0);
    rst_n = 1'b1;
    step();

    // Contention after reset goes to req0, the next contention to req1
    q_data = '{4'h5, 4'h6};
    run_frame(1, 1'b1, -1, 0, 0);
    step();
    q_data = '{4'h7, 4'h1, 4'h8};
    run_frame(0, 1'b1, -1, 0, 1);
    check("rr_prio_back_to_0", m_prio, 0);

    // req0 frame F,3,0 -> 6
    q_data = '{4'hF, 4'h3, 4'h0};
    run_frame(0, 1'b0, -1, 0, 0);

    // Single beat on req1, result held 5 cycles
    q_data = '{4'b1010};
    run_frame(1, 1'b0, -1, 0, 5);

    // Reset mid-frame after two accepted beats abandons the frame
    set_req(0, 1'b1, 4'h7, 1'b0);
    step();
    check("rst_frame_rdy", req0_ready, 1);
    step();
    step();
    rst_n = 1'b0;
    set_req(0, 1'b0, 4'h0, 1'b0);
    step();
    rst_n = 1'b1;
    check_idle_outputs("midreset");
    check("midreset_id", res_id, 0);
    m_prio = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("midreset_no_result", res_valid, 0);
    end
    q_data = '{4'h1};
    run_frame(0, 1'b0, -1, 0, 0);

    // Granted requester stalls 3 cycles mid-frame while the other contends
    q_data = '{4'h3, 4'hE, 4'h9, 4'h1};
    run_frame(1, 1'b1, 2, 3, 0);

    // 64 beats of F overflow an 8-bit accumulator
    q_data.delete();
    for (int i = 0; i < 64; i++) q_data.push_back(4'hF);
    run_frame(0, 1'b0, -1, 0, 0);

    // Random frames
    for (int f = 0; f < 25; f++) begin
      len = $urandom_range(1, 8);
      q_data.delete();
      for (int i = 0; i < len; i++) q_data.push_back(4'($urandom));
      run_frame($urandom_range(0, 1), ($urandom_range(0, 2) == 0),
                (len > 1) ? $urandom_range(1, len - 1) : -1,
                $urandom_range(0, 2), $urandom_range(0, 3));
      for (int i = 0; i < $urandom_range(0, 2); i++) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
